mem_port_arbiter: RTL and testbench

//  Shares the single external memory bus between instruction fetch (I-side) and
//  the load/store path driven by the EX/MEM stages (D-side). Grants one

---
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the external memory bus between instruction fetch (I) and load/store (D).
// Define ARB_STARVE_GUARD_EN to build the fetch starvation guard (MAX_D_STREAK).
module mem_port_arbiter
`ifdef ARB_STARVE_GUARD_EN
  #(parameter int unsigned MAX_D_STREAK = 4)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_kill,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_RESP_I,
    ST_RESP_D
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_i_pend;
  logic w_guard_hit;
  logic w_grant_i;
  logic w_grant_d;
  logic w_capture;
  logic w_kill_now;
  logic r_kill_pend;

  logic              r_i_ack;
  logic [DATA_W-1:0] r_i_rdata;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [BE_W-1:0]   r_bus_be;

  assign w_i_pend   = i_req & ~i_kill;
  assign w_kill_now = r_kill_pend | i_kill;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

  logic [STREAK_W-1:0] r_d_streak;

  // Counts D grants taken while a live fetch was waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_streak <= '0;
    end else if (w_grant_i || !i_req) begin
      r_d_streak <= '0;
    end else if (w_grant_d && !i_kill) begin
      r_d_streak <= r_d_streak + STREAK_W'(1);
    end
  end

  assign w_guard_hit = (r_d_streak == STREAK_W'(MAX_D_STREAK));
`else
  assign w_guard_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (d_req && !(w_i_pend && w_guard_hit)) begin
          w_grant_d = 1'b1;
        end else if (w_i_pend) begin
          w_grant_i = 1'b1;
        end
      end
      ST_BUSY_I: begin
        if (bus_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP_I;
        end
      end
      ST_BUSY_D: begin
        if (bus_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP_D;
        end
      end
      ST_RESP_I: begin
        w_state_nxt = ST_IDLE;
        w_grant_d   = d_req;
      end
      ST_RESP_D: begin
        // A still-asserted d_req is back-to-back D traffic: let IDLE arbitrate it.
        w_state_nxt = ST_IDLE;
        w_grant_i   = w_i_pend & ~d_req;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_grant_d) begin
      w_state_nxt = ST_BUSY_D;
    end else if (w_grant_i) begin
      w_state_nxt = ST_BUSY_I;
    end
  end

  // A redirect during the fetch lets the bus cycle finish but swallows its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kill_pend <= 1'b0;
    end else begin
      r_kill_pend <= (r_state == ST_BUSY_I) && !bus_ack && w_kill_now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_ack     <= 1'b0;
      r_d_rdata   <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      if (w_grant_d) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= d_we;
        r_bus_addr  <= d_addr;
        r_bus_wdata <= d_wdata;
        r_bus_be    <= d_be;
      end else if (w_grant_i) begin
        r_bus_req  <= 1'b1;
        r_bus_we   <= 1'b0;
        r_bus_addr <= i_addr;
        r_bus_be   <= {BE_W{1'b1}};
      end else if (w_capture) begin
        r_bus_req <= 1'b0;
      end
      if (w_capture && (r_state == ST_BUSY_D)) begin
        r_d_rdata <= bus_rdata;
        r_d_ack   <= 1'b1;
      end
      if (w_capture && (r_state == ST_BUSY_I) && !w_kill_now) begin
        r_i_rdata <= bus_rdata;
        r_i_ack   <= 1'b1;
      end
    end
  end

  assign i_ack     = r_i_ack;
  assign i_rdata   = r_i_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_be    = r_bus_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random run
// compared every cycle against a transaction-level owner/response model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_kill;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: who owns the bus, who is being answered, and the expected outputs.
  localparam int NONE = 0;
  localparam int SIDE_I = 1;
  localparam int SIDE_D = 2;
  int          m_owner  = NONE;
  int          m_answer = NONE;
  bit          m_killed = 1'b0;
  int          m_streak = 0;
  bit          m_valid  = 1'b0;
  logic        e_bus_req, e_bus_we, e_i_ack, e_d_ack;
  logic [31:0] e_bus_addr, e_bus_wdata, e_i_rdata, e_d_rdata;
  logic [3:0]  e_bus_be;

  // Slave model.
  int          s_wait = 0;
  int          s_cnt  = 0;
  bit          s_rand = 1'b0;
  bit          s_spur = 1'b0;
  logic [31:0] s_data = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Applies one clock of the arbitration rules to the inputs about to be sampled.
  task automatic model_step();
    int who;
    bit fetch_live;
    who = NONE;
    fetch_live = i_req && !i_kill;
    if (rst) begin
      m_owner = NONE; m_answer = NONE; m_killed = 1'b0; m_streak = 0; m_valid = 1'b1;
      e_bus_req = 1'b0; e_bus_we = 1'b0; e_bus_addr = 32'h0; e_bus_wdata = 32'h0;
      e_bus_be = 4'h0; e_i_ack = 1'b0; e_d_ack = 1'b0; e_i_rdata = 32'h0; e_d_rdata = 32'h0;
      return;
    end
    e_i_ack = 1'b0;
    e_d_ack = 1'b0;
    if (m_owner != NONE) begin
      if (m_owner == SIDE_I && i_kill) m_killed = 1'b1;
      if (bus_ack) begin
        if (m_owner == SIDE_D) begin
          e_d_rdata = bus_rdata; e_d_ack = 1'b1;
        end else if (!m_killed) begin
          e_i_rdata = bus_rdata; e_i_ack = 1'b1;
        end
        m_answer = m_owner; m_owner = NONE; m_killed = 1'b0; e_bus_req = 1'b0;
      end
    end else if (m_answer == SIDE_D) begin
      m_answer = NONE;
      if (fetch_live && !d_req) who = SIDE_I;
    end else if (m_answer == SIDE_I) begin
      m_answer = NONE;
      if (d_req) who = SIDE_D;
    end else begin
      if (d_req && fetch_live) begin
`ifdef ARB_STARVE_GUARD_EN
        who = (m_streak == 4) ? SIDE_I : SIDE_D;
`else
        who = SIDE_D;
`endif
      end else if (d_req) who = SIDE_D;
      else if (fetch_live) who = SIDE_I;
    end
`ifdef ARB_STARVE_GUARD_EN
    if (who == SIDE_I || !i_req) m_streak = 0;
    else if (who == SIDE_D && !i_kill) m_streak = m_streak + 1;
`endif
    if (who == SIDE_D) begin
      m_owner = SIDE_D; e_bus_req = 1'b1; e_bus_we = d_we; e_bus_addr = d_addr;
      e_bus_wdata = d_wdata; e_bus_be = d_be;
    end else if (who == SIDE_I) begin
      m_owner = SIDE_I; e_bus_req = 1'b1; e_bus_we = 1'b0; e_bus_addr = i_addr;
      e_bus_be = 4'hF;
    end
  endtask

  task automatic slave_drive();
    if (bus_req === 1'b1) begin
      if (s_cnt >= s_wait) begin
        bus_ack = 1'b1;
        bus_rdata = s_rand ? $urandom : s_data;
        s_cnt = 0;
        if (s_rand) s_wait = $urandom_range(0, 3);
      end else begin
        bus_ack = 1'b0;
        s_cnt++;
      end
    end else begin
      bus_ack = s_spur && ($urandom_range(0, 7) == 0);
      if (s_rand) bus_rdata = $urandom;
      s_cnt = 0;
    end
  endtask

  // One clock: advance the model, sample mid-cycle, compare, then drive the slave.
  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
    if (m_valid) begin
      chk("bus_req", 32'(bus_req), 32'(e_bus_req));
      chk("i_ack", 32'(i_ack), 32'(e_i_ack));
      chk("d_ack", 32'(d_ack), 32'(e_d_ack));
      chk("i_rdata", i_rdata, e_i_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
      if (e_bus_req) begin
        chk("bus_we", 32'(bus_we), 32'(e_bus_we));
        chk("bus_addr", bus_addr, e_bus_addr);
        chk("bus_be", 32'(bus_be), 32'(e_bus_be));
        if (e_bus_we) chk("bus_wdata", bus_wdata, e_bus_wdata);
      end
    end
    slave_drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0; i_addr = 32'h0; i_kill = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    int ng;
    int n;
    bit prev_req;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    do_reset();

    // Reset state
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'h0);
    chk("rst_i_ack", 32'(i_ack), 32'h0);
    chk("rst_d_ack", 32'(d_ack), 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);

    // 1: plain fetch, slave acks two cycles after bus_req
    s_wait = 2; s_data = 32'hDEADBEEF;
    i_req = 1'b1; i_addr = 32'h40;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        chk("t1_bus_req", 32'(bus_req), 32'h1);
        chk("t1_bus_we", 32'(bus_we), 32'h0);
        chk("t1_bus_be", 32'(bus_be), 32'hF);
        chk("t1_bus_addr", bus_addr, 32'h40);
      end
      if (i_ack) begin lat = k; break; end
    end
    chk("t1_lat", 32'(lat), 32'd4);
    chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
    i_req = 1'b0;
    tick();
    chk("t1_ack_width", 32'(i_ack), 32'h0);

    // 2: simultaneous requests, D first, I handed over straight from the D response
    s_wait = 0; s_data = 32'hCAFEF00D;
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h12345678; d_be = 4'b0011;
    tick();
    chk("t2_d_we", 32'(bus_we), 32'h1);
    chk("t2_d_addr", bus_addr, 32'h100);
    chk("t2_d_wdata", bus_wdata, 32'h12345678);
    chk("t2_d_be", 32'(bus_be), 32'h3);
    tick();
    chk("t2_d_ack", 32'(d_ack), 32'h1);
    chk("t2_resp_bus_req", 32'(bus_req), 32'h0);
    d_req = 1'b0;
    s_data = 32'h11223344;
    tick();
    chk("t2_i_bus_req", 32'(bus_req), 32'h1);
    chk("t2_i_addr", bus_addr, 32'h80);
    chk("t2_i_we", 32'(bus_we), 32'h0);
    tick();
    chk("t2_i_ack", 32'(i_ack), 32'h1);
    chk("t2_i_rdata", i_rdata, 32'h11223344);
    i_req = 1'b0;
    tick();

    // 3: kill during the fetch: bus cycle completes, no ack, i_rdata kept
    s_wait = 3; s_data = 32'h0BADF00D;
    i_req = 1'b1; i_addr = 32'hC0;
    tick();
    chk("t3_bus_req", 32'(bus_req), 32'h1);
    i_kill = 1'b1; i_req = 1'b0;
    tick();
    i_kill = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (i_ack) seen++;
    end
    chk("t3_no_i_ack", 32'(seen), 32'h0);
    chk("t3_bus_done", 32'(bus_req), 32'h0);
    chk("t3_i_rdata", i_rdata, 32'h11223344);

    // 6: d_req still high in the D response goes through IDLE before the next grant
    s_wait = 0; s_data = 32'hA5A5A5A5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    tick();
    chk("t6_bus_req1", 32'(bus_req), 32'h1);
    tick();
    chk("t6_d_ack1", 32'(d_ack), 32'h1);
    chk("t6_d_rdata1", d_rdata, 32'hA5A5A5A5);
    d_addr = 32'h304; s_data = 32'h5A5A5A5A;
    tick();
    chk("t6_idle_gap", 32'(bus_req), 32'h0);
    tick();
    chk("t6_bus_req2", 32'(bus_req), 32'h1);
    chk("t6_addr2", bus_addr, 32'h304);
    tick();
    chk("t6_d_ack2", 32'(d_ack), 32'h1);
    d_req = 1'b0;
    tick();

    // 4: reset while the load is on the bus
    s_wait = 5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    tick();
    chk("t4_bus_req", 32'(bus_req), 32'h1);
    rst = 1'b1; d_req = 1'b0;
    tick();
    chk("t4_bus_drop", 32'(bus_req), 32'h0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (d_ack) seen++;
    end
    chk("t4_no_d_ack", 32'(seen), 32'h0);
    chk("t4_idle", 32'(bus_req), 32'h0);
    chk("t4_d_rdata", d_rdata, 32'h0);

    // 5: both sides held continuously; record who wins each grant
    do_reset();
    s_wait = 0; s_data = 32'h0;
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    ng = 0; n = 0; prev_req = 1'b0;
    while (ng < 10 && n < 200) begin
      tick();
      n++;
      if (bus_req && !prev_req) begin
`ifdef ARB_STARVE_GUARD_EN
        chk($sformatf("t5_grant%0d_is_i", ng), 32'(bus_addr == 32'h500), 32'((ng % 5) == 4));
`else
        chk($sformatf("t5_grant%0d_is_i", ng), 32'(bus_addr == 32'h500), 32'h0);
`endif
        ng++;
      end
      prev_req = bus_req;
    end
    chk("t5_grants", 32'(ng), 32'd10);

    // Random traffic against the model
    do_reset();
    s_rand = 1'b1; s_spur = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      i_kill = 1'b0;
      if (i_req && i_ack) begin
        i_req = 1'($urandom_range(0, 1)); i_addr = $urandom & 32'hFFFF_FFFC;
      end else if (i_req && $urandom_range(0, 19) == 0) begin
        i_kill = 1'b1; i_req = 1'($urandom_range(0, 1)); i_addr = $urandom & 32'hFFFF_FFFC;
      end else if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if ((d_req && d_ack) || (!d_req && $urandom_range(0, 2) == 0)) begin
        d_req = (d_req && d_ack) ? 1'($urandom_range(0, 1)) : 1'b1;
        d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
        d_be = 4'($urandom_range(0, 15));
      end
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
